// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential floating-point ALU.
package fp_pkg;

    typedef enum logic [1:0] {
        ModeAdd  = 2'd0,
        ModeSub  = 2'd1,
        ModeMul  = 2'd2,
        ModePass = 2'd3
    } fp_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StExec,
        StNorm,
        StOut
    } fp_state_e;

    // Bit positions inside out_flags = {overflow, underflow, zero}
    localparam int unsigned FlagZero  = 0;
    localparam int unsigned FlagUnder = 1;
    localparam int unsigned FlagOver  = 2;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_max_exp(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_alu_seq_if.sv
// Request/result bundle between operand fetch, the FP ALU and the result collector.
interface fp_alu_seq_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic [W-1:0] out;
    logic [2:0]   out_flags;

    modport master (
        output in_valid, mode, in_a, in_b,
        input  in_ready, out_valid, out, out_flags
    );

    modport slave (
        input  in_valid, mode, in_a, in_b,
        output in_ready, out_valid, out, out_flags
    );

endinterface

// File: rtl/fp_normalize.sv
// Leading-one detect and left shift so the first set bit lands in the MSB.
module fp_normalize #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]           value,
    output logic [WIDTH-1:0]           shifted,
    output logic [$clog2(WIDTH+1)-1:0] lead_zeros
);
    localparam int unsigned LZW = $clog2(WIDTH + 1);

    logic found;

    always_comb begin
        found      = 1'b0;
        lead_zeros = LZW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                found      = 1'b1;
                lead_zeros = LZW'(WIDTH - 1 - i);
            end
        end
        shifted = value << lead_zeros;
    end

endmodule

// File: rtl/fp_alu_seq.sv
// Sequential add/sub/mul/pass floating-point unit with a fixed five-cycle FSM.
module fp_alu_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
) (
    input logic         clk,
    input logic         rst_n,
    fp_alu_seq_if.slave bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned AW   = SW + 4;  // carry, significand, guard, round, sticky
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned NW   = (AW > PW) ? AW : PW;
    localparam int unsigned LZW  = $clog2(NW + 1);
    localparam int unsigned XW   = EXP_W + LZW + 2;
    localparam int unsigned BIAS = fp_bias(EXP_W);
    localparam int unsigned EMAX = fp_max_exp(EXP_W);

    fp_state_e    state_q;
    fp_mode_e     mode_q;
    logic [W-1:0] a_q, b_q;
    logic         in_ready_q, out_valid_q;
    logic [W-1:0] out_q;
    logic [2:0]   out_flags_q;

    logic                    sign_d, sign_q, eff_sub_d, eff_sub_q, byp_d, byp_q;
    logic [EXP_W-1:0]        diff_d, diff_q;
    logic signed [XW-1:0]    eref_d, eref_q;
    logic [SW-1:0]           big_d, big_q, small_d, small_q;
    logic [W-1:0]            byp_res_d, byp_res_q, res_d, res_q;
    logic [2:0]              byp_flags_d, byp_flags_q, res_flags_d, res_flags_q;
    logic [NW-1:0]           acc_d, acc_q;

    logic             sa, sb_eff, za, zb, a_ge_b;
    logic [EXP_W-1:0] ea, eb;
    logic [SW-1:0]    siga, sigb;

    assign sa     = a_q[W-1];
    assign ea     = a_q[W-2 -: EXP_W];
    assign eb     = b_q[W-2 -: EXP_W];
    assign siga   = {1'b1, a_q[MAN_W-1:0]};
    assign sigb   = {1'b1, b_q[MAN_W-1:0]};
    assign sb_eff = b_q[W-1] ^ (mode_q == ModeSub);
    assign za     = (ea == '0);
    assign zb     = (eb == '0);
    assign a_ge_b = (a_q[W-2:0] >= b_q[W-2:0]);

    // Unpack: order by magnitude for add/sub and resolve trivially-known results.
    always_comb begin
        sign_d      = a_ge_b ? sa : sb_eff;
        eff_sub_d   = sa ^ sb_eff;
        big_d       = a_ge_b ? siga : sigb;
        small_d     = a_ge_b ? sigb : siga;
        diff_d      = a_ge_b ? (ea - eb) : (eb - ea);
        eref_d      = XW'(a_ge_b ? ea : eb);
        byp_d       = 1'b0;
        byp_res_d   = '0;
        byp_flags_d = '0;
        unique case (mode_q)
            ModeMul: begin
                sign_d  = sa ^ b_q[W-1];
                big_d   = siga;
                small_d = sigb;
                eref_d  = XW'(ea) + XW'(eb) - XW'(BIAS);
                if (za || zb) begin
                    byp_d                 = 1'b1;
                    byp_flags_d[FlagZero] = 1'b1;
                end
            end
            ModePass: begin
                byp_d = 1'b1;
                if (za) byp_flags_d[FlagZero] = 1'b1;
                else    byp_res_d = a_q;
            end
            default: begin
                if (za && zb) begin
                    byp_d                 = 1'b1;
                    byp_flags_d[FlagZero] = 1'b1;
                end else if (za) begin
                    byp_d     = 1'b1;
                    byp_res_d = {sb_eff, b_q[W-2:0]};
                end else if (zb) begin
                    byp_d     = 1'b1;
                    byp_res_d = a_q;
                end
            end
        endcase
    end

    logic [SW+2:0] small_ext, small_sh;
    logic          sticky;
    logic [AW-1:0] big_ext, small_al, sum;
    logic [PW-1:0] prod;

    // Exec: bits shifted past the guard/round positions collapse into the sticky bit.
    always_comb begin
        small_ext = {small_q, 3'b000};
        sticky    = 1'b0;
        for (int i = 0; i < int'(SW + 3); i++) begin
            if (i < int'(diff_q)) sticky |= small_ext[i];
        end
        small_sh    = small_ext >> diff_q;
        small_sh[0] = small_sh[0] | sticky;
        small_al    = {1'b0, small_sh};
        big_ext     = {1'b0, big_q, 3'b000};
        sum         = eff_sub_q ? (big_ext - small_al) : (big_ext + small_al);
        prod        = PW'(big_q) * PW'(small_q);
        acc_d       = (mode_q == ModeMul) ? (NW'(prod) << (NW - PW)) : (NW'(sum) << (NW - AW));
    end

    logic [NW-1:0]        norm_val;
    logic [LZW-1:0]       norm_lz;
    logic signed [XW-1:0] exp_n;
    logic                 norm_unused;

    fp_normalize #(
        .WIDTH (NW)
    ) u_norm (
        .value      (acc_q),
        .shifted    (norm_val),
        .lead_zeros (norm_lz)
    );

    // The leading one sits at NW-2 when the result exponent equals eref.
    assign norm_unused = ^{norm_val[NW-1], norm_val[NW-MAN_W-2:0]};

    always_comb begin
        exp_n       = eref_q + XW'(1) - XW'(norm_lz);
        res_d       = '0;
        res_flags_d = '0;
        if (byp_q) begin
            res_d       = byp_res_q;
            res_flags_d = byp_flags_q;
        end else if (acc_q == '0) begin
            res_flags_d[FlagZero] = 1'b1;
        end else if (exp_n > $signed(XW'(EMAX))) begin
            res_d                 = {sign_q, {(W-1){1'b1}}};
            res_flags_d[FlagOver] = 1'b1;
        end else if (exp_n < $signed(XW'(1))) begin
            res_flags_d[FlagUnder] = 1'b1;
            res_flags_d[FlagZero]  = 1'b1;
        end else begin
            res_d = {sign_q, exp_n[EXP_W-1:0], norm_val[NW-2 -: MAN_W]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= ModeAdd;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_flags_q <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            byp_q       <= 1'b0;
            diff_q      <= '0;
            eref_q      <= '0;
            big_q       <= '0;
            small_q     <= '0;
            byp_res_q   <= '0;
            byp_flags_q <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    out_valid_q <= 1'b0;
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        mode_q     <= fp_mode_e'(bus.mode);
                        in_ready_q <= 1'b0;
                        state_q    <= StUnpack;
                    end
                end
                StUnpack: begin
                    sign_q      <= sign_d;
                    eff_sub_q   <= eff_sub_d;
                    byp_q       <= byp_d;
                    diff_q      <= diff_d;
                    eref_q      <= eref_d;
                    big_q       <= big_d;
                    small_q     <= small_d;
                    byp_res_q   <= byp_res_d;
                    byp_flags_q <= byp_flags_d;
                    state_q     <= StExec;
                end
                StExec: begin
                    acc_q   <= acc_d;
                    state_q <= StNorm;
                end
                StNorm: begin
                    res_q       <= res_d;
                    res_flags_q <= res_flags_d;
                    state_q     <= StOut;
                end
                StOut: begin
                    out_q       <= res_q;
                    out_flags_q <= res_flags_q;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_alu_seq.sv
// Bench for fp_alu_seq: directed cases plus random operations against an exact-integer model.
module tb_fp_alu_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;
    localparam int BIGW  = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fp_alu_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_alu_seq #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int msb_of(input logic [BIGW-1:0] v);
        for (int i = BIGW - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    // Exact value = sig * 2^(e - BIAS - MAN_W); compute exactly, then truncate toward zero.
    function automatic logic [18:0] ref_model(input logic [1:0] m, input logic [15:0] a,
                                              input logic [15:0] b);
        logic sa, sb, sb2, rs;
        int ea, eb, emin, msb, bexp;
        logic [BIGW-1:0] ma, mb, av, bv, r, mant;
        sa = a[15];
        sb = b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = BIGW'({1'b1, a[6:0]});
        mb = BIGW'({1'b1, b[6:0]});
        if (m == 2'd3) begin
            if (ea == 0) return {3'b001, 16'h0000};
            return {3'b000, a};
        end
        if (m == 2'd2) begin
            if (ea == 0 || eb == 0) return {3'b001, 16'h0000};
            r    = ma * mb;
            rs   = sa ^ sb;
            msb  = msb_of(r);
            bexp = ea + eb - BIAS - 2 * MAN_W + msb;
        end else begin
            sb2 = sb ^ (m == 2'd1);
            if (ea == 0 && eb == 0) return {3'b001, 16'h0000};
            if (ea == 0) return {3'b000, sb2, b[14:0]};
            if (eb == 0) return {3'b000, a};
            emin = (ea < eb) ? ea : eb;
            av   = ma << (ea - emin);
            bv   = mb << (eb - emin);
            if (sa == sb2) begin r = av + bv; rs = sa; end
            else if (av >= bv) begin r = av - bv; rs = sa; end
            else begin r = bv - av; rs = sb2; end
            if (r == '0) return {3'b001, 16'h0000};
            msb  = msb_of(r);
            bexp = emin - MAN_W + msb;
        end
        if (bexp > 255) return {3'b100, rs, 15'h7FFF};
        if (bexp < 1) return {3'b011, 16'h0000};
        mant = (msb >= MAN_W) ? (r >> (msb - MAN_W)) : (r << (MAN_W - msb));
        return {3'b000, rs, 8'(bexp), mant[6:0]};
    endfunction

    task automatic wait_result(input string tag, input logic [15:0] exp_out,
                               input logic [2:0] exp_flags);
        int n;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " latency"}, 32'(n), 32'd5);
        check_eq({tag, " out"}, 32'(bus.out), 32'(exp_out));
        check_eq({tag, " flags"}, 32'(bus.out_flags), 32'(exp_flags));
        check_eq({tag, " ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_out,
                          input logic [2:0] exp_flags);
        check_eq({tag, " idle ready"}, 32'(bus.in_ready), 32'd1);
        bus.mode     = m;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.mode     = 2'($urandom_range(0, 3));
        wait_result(tag, exp_out, exp_flags);
        @(negedge clk);
        check_eq({tag, " pulse"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [1:0]  dm [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0,
                             2'd2};
    logic [15:0] da [12] = '{16'h3FC0, 16'h3F80, 16'h3F80, 16'h3FC0, 16'h7F80, 16'h0080,
                             16'h3F80, 16'h0012, 16'hC123, 16'h0000, 16'hBF80, 16'h4000};
    logic [15:0] db [12] = '{16'h3FC0, 16'h3F80, 16'h3580, 16'h4000, 16'h4000, 16'h3F00,
                             16'h3B80, 16'h4000, 16'h1234, 16'h4000, 16'h8000, 16'h0055};
    logic [15:0] dq [12] = '{16'h4040, 16'h0000, 16'h3F7F, 16'h4040, 16'h7FFF, 16'h0000,
                             16'h3F80, 16'h0000, 16'hC123, 16'hC000, 16'hBF80, 16'h0000};
    logic [2:0]  df [12] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b011, 3'b000, 3'b001,
                             3'b000, 3'b000, 3'b000, 3'b001};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  m;
        logic [15:0] a, b;
        logic [18:0] r1, r2;
        int          sel, pulses;

        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (2) @(negedge clk);
        check_eq("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset out", 32'(bus.out), 32'd0);
        check_eq("reset flags", 32'(bus.out_flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_op($sformatf("dir%0d", i), dm[i], da[i], db[i], dq[i], df[i]);

        // Request held high while busy: only the first completes, the second waits for ready.
        r1 = ref_model(2'd2, 16'h3FC0, 16'h4000);
        r2 = ref_model(2'd0, 16'h4000, 16'hC0A0);
        bus.mode = 2'd2; bus.in_a = 16'h3FC0; bus.in_b = 16'h4000; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mode = 2'd0; bus.in_a = 16'h4000; bus.in_b = 16'hC0A0;
        wait_result("busy first", r1[15:0], r1[18:16]);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result("busy second", r2[15:0], r2[18:16]);
        @(negedge clk);

        // Reset pulse while the operation is in EXEC.
        bus.mode = 2'd0; bus.in_a = 16'h3FC0; bus.in_b = 16'h3FC0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst out", 32'(bus.out), 32'd0);
        check_eq("midrst in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check_eq("midrst no result", 32'(pulses), 32'd0);
        run_op("post rst", 2'd0, 16'h3FC0, 16'h3FC0, 16'h4040, 3'b000);

        for (int i = 0; i < 200; i++) begin
            m   = 2'($urandom_range(0, 3));
            a   = 16'($urandom);
            b   = 16'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) a[14:7] = 8'h00;
            if (sel == 1) b[14:7] = 8'h00;
            if (sel >= 4) b[14:7] = a[14:7] - 8'($urandom_range(0, 9));
            if (sel == 5) b[6:0] = a[6:0];
            r1 = ref_model(m, a, b);
            run_op($sformatf("rand%0d m%0d %h %h", i, m, a, b), m, a, b, r1[15:0], r1[18:16]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_alu_seq.md
# fp_alu_seq

Parametrised sequential floating-point unit that generalises the team's 16-bit add/multiply calculator. It has configurable exponent and mantissa widths, add, subtract and multiply modes, a ready/valid input handshake, and status flags. It accepts one operation at a time, computes it through a fixed-latency FSM, and presents the result for one cycle. It sits between operand-fetch logic and a result collector in the lab datapath.

## Interface
- `EXP_W`, default 8: exponent width, at least 3. Bias is 2^(EXP_W-1)-1.
- `MAN_W`, default 7: stored mantissa width (hidden 1 not stored), at least 2.
- `W` (localparam) = 1+EXP_W+MAN_W: word width. The defaults give bfloat16.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit idle and able to accept.
- `mode` in 2: 0 ADD (a+b), 1 SUB (a−b), 2 MUL (a×b), 3 PASS (returns a).
- `in_a`, `in_b` in W: operands, format {sign, exp, man}.
- `out_valid` out 1: result strobe, one cycle.
- `out` out W: result.
- `out_flags` out 3: {overflow, underflow, zero}.

## Operation
- **Number model:**
  - exp == 0 means zero; mantissa and sign are ignored (denormals flush to zero).
  - Every other exponent, including all-ones, is a normal number. There is no Inf or NaN.
- **Rounding:** the result is the exact mathematical result truncated toward zero. ADD/SUB alignment must keep guard, round and sticky bits so that truncation is exact.
- **Zero result:** always encoded +0 (0x0000 at default widths), with zero flag = 1.
- **Overflow:**
  - Applies when the biased result exponent exceeds 2^EXP_W−1.
  - The result saturates to {sign, all-ones exp, all-ones man}, with overflow = 1.
- **Underflow:**
  - Applies when the biased result exponent is below 1 and the exact result is nonzero.
  - The result is +0, with underflow = 1 and zero = 1.
- **Zero operands:**
  - ADD/SUB with one zero operand return the other operand (negated for 0−b), exact and with no flags.
  - MUL with any zero operand returns +0 with zero = 1.
- **PASS:** returns in_a unchanged; flags are 0 unless in_a is zero, in which case the result is +0 with zero = 1.
- **MUL sign:** XOR of the operand signs.
- **MUL exponent:** ea+eb−bias, computed at width EXP_W+2 signed.
- **FSM states:** IDLE → UNPACK → EXEC → NORM → OUT → IDLE.
  - IDLE: in_ready = 1. in_valid=1 captures in_a, in_b and mode, then moves to UNPACK.
  - UNPACK: detect zeros, compute exponent difference or sum, swap operands so |a| ≥ |b| for ADD/SUB.
  - EXEC: align and add/subtract, or multiply the (MAN_W+1)-bit significands.
  - NORM: leading-one normalise, truncate, check overflow/underflow, pack.
  - OUT: out_valid = 1, out and out_flags valid, then unconditionally to IDLE.
- Requests made while in_ready = 0 are ignored, not queued.

## Timing
- **Reset values:**
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out = 0
  - out_flags = 0
- **Latency:** a request accepted at rising edge k produces out_valid high during the cycle after edge k+4.
- **Throughput:** one operation per 5 cycles. in_ready drops the cycle after acceptance and returns the cycle after OUT.
- **Output hold:** out and out_flags are registered and hold their values until the next OUT.
- **out_valid:** exactly one cycle per accepted request.
- **Reset mid-operation:** rst_n low in any state immediately forces the reset values. The in-flight operation is discarded and produces no out_valid.
- **Inputs:** operand inputs are sampled only at acceptance. Later changes have no effect.

## Structure
- **Package `fp_pkg`:**
  - `fp_mode_e` (ADD/SUB/MUL/PASS)
  - `fp_state_e`
  - flag bit indices
  - helper functions for bias and max-exponent derived from EXP_W
- **Sub-module `fp_normalize`:** combinational leading-one detect plus shift, parametrised on input width. It is instantiated once in NORM for both the ADD/SUB and MUL paths.
- **Target size:** 120–400 lines of RTL total.

## Test plan
All values use default widths (bfloat16).
- **ADD:** mode 0, a=0x3FC0, b=0x3FC0 → out=0x4040, flags=000, out_valid exactly 5 cycles after acceptance.
- **SUB to zero, and sticky truncation:**
  - mode 1, a=0x3F80, b=0x3F80 → out=0x0000, flags=001.
  - mode 1, a=0x3F80, b=0x3580 → out=0x3F7F (truncation toward zero with sticky).
- **MUL:**
  - a=0x3FC0, b=0x4000 → 0x4040.
  - a=0x7F80, b=0x4000 → 0x7FFF, flags=100 (overflow).
  - a=0x0080, b=0x3F00 → 0x0000, flags=011 (underflow).
- **ADD truncation:** a=0x3F80, b=0x3B80 → out=0x3F80.
- **Busy request ignored:** in_valid held high during the busy cycles with other operands → only the first request completes, and the second is taken only when in_ready = 1.
- **Reset mid-operation:** pulse rst_n low during EXEC → no out_valid; out=0, in_ready=1. A following request completes normally.
